// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, the NOP encoding and
// the skid-buffer state type used by the IF/ID stage.
package mips_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JADDR_HI = 25;
  localparam int JADDR_LO = 0;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Encoding equals the number of held entries, so occupancy is a direct cast.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/mips_predecode.sv
// Combinational MIPS field extraction; shared by the IF/ID buffer and decode.
module mips_predecode
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [XLEN-1:0] imm_sext,
  output logic [25:0]     jaddr
);

  assign opcode   = instr[OPC_HI:OPC_LO];
  assign rs       = instr[RS_HI:RS_LO];
  assign rt       = instr[RT_HI:RT_LO];
  assign rd       = instr[RD_HI:RD_LO];
  assign shamt    = instr[SHAMT_HI:SHAMT_LO];
  assign funct    = instr[FUNCT_HI:FUNCT_LO];
  assign imm_sext = {{(XLEN-16){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
  assign jaddr    = instr[JADDR_HI:JADDR_LO];

endmodule

// File: rtl/if_id_skid_buffer.sv
// Two-entry IF/ID skid buffer: holds fetched {PC+4, instr} pairs in FIFO order,
// presents the head with pre-decoded fields, and flushes on redirect.
module if_id_skid_buffer
  import mips_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter bit ZERO_WHEN_EMPTY = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [XLEN-1:0] out_imm_sext,
  output logic [25:0]     out_jaddr,
  output logic [1:0]      occupancy
);

  buf_state_e      state_q, state_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [XLEN-1:0] head_instr_q, head_instr_d;
  logic [XLEN-1:0] tail_pc_q, tail_pc_d;
  logic [XLEN-1:0] tail_instr_q, tail_instr_d;
  logic            push;
  logic            pop;

  // Handshake flags come from registered state only.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d      = ONE;
            head_pc_d    = in_pc;
            head_instr_d = in_instr;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_pc_d    = in_pc;
            head_instr_d = in_instr;
          end else if (push) begin
            state_d      = FULL;
            tail_pc_d    = in_pc;
            tail_instr_d = in_instr;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d      = ONE;
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

  // Masking the head before pre-decode zeroes every derived field as well.
  logic            show_head;
  logic [XLEN-1:0] vis_instr;

  assign show_head = out_valid | ~ZERO_WHEN_EMPTY;
  assign out_pc    = show_head ? head_pc_q : '0;
  assign vis_instr = show_head ? head_instr_q : INSTR_NOP[XLEN-1:0];
  assign out_instr = vis_instr;

  mips_predecode #(.XLEN(XLEN)) u_predecode (
    .instr    (vis_instr),
    .opcode   (out_opcode),
    .rs       (out_rs),
    .rt       (out_rt),
    .rd       (out_rd),
    .shamt    (out_shamt),
    .funct    (out_funct),
    .imm_sext (out_imm_sext),
    .jaddr    (out_jaddr)
  );

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed-vector bench for the IF/ID skid buffer with hand-computed expectations.
module tb_if_id_skid_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr, out_imm_sext;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [25:0] out_jaddr;
  logic [1:0]  occupancy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_id_skid_buffer #(.XLEN(32), .ZERO_WHEN_EMPTY(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm_sext(out_imm_sext),
    .out_jaddr(out_jaddr), .occupancy(occupancy)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one edge; outputs are then observed and inputs driven 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    step(); step();
    rst = 1'b0;
    check_vec("rst_occ", occupancy, 0);
    check_vec("rst_valid", out_valid, 0);
    check_vec("rst_in_ready", in_ready, 1);
    check_vec("rst_pc", out_pc, 0);
    check_vec("rst_instr", out_instr, 0);

    // lw $3,4($2)
    in_valid = 1'b1; in_pc = 32'h4; in_instr = 32'h8C43_0004; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_vec("lw_valid", out_valid, 1);
    check_vec("lw_pc", out_pc, 32'h4);
    check_vec("lw_opcode", out_opcode, 32'h23);
    check_vec("lw_rs", out_rs, 2);
    check_vec("lw_rt", out_rt, 3);
    check_vec("lw_imm", out_imm_sext, 32'h4);
    check_vec("lw_jaddr", out_jaddr, 32'h043_0004);
    step();
    check_vec("lw_drained", out_valid, 0);

    // Stall decode, fill the buffer, offer a third word that must be ignored.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h8; in_instr = 32'h2001_FFFF;
    step();
    in_pc = 32'hC; in_instr = 32'h0022_1820;
    step();
    check_vec("full_occ", occupancy, 2);
    check_vec("full_in_ready", in_ready, 0);
    check_vec("full_imm", out_imm_sext, 32'hFFFF_FFFF);
    check_vec("full_rt", out_rt, 1);
    in_pc = 32'h10; in_instr = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    check_vec("ignored_occ", occupancy, 2);
    check_vec("ignored_head", out_instr, 32'h2001_FFFF);
    check_vec("ignored_pc", out_pc, 32'h8);
    out_ready = 1'b1;
    step();
    check_vec("second_instr", out_instr, 32'h0022_1820);
    check_vec("second_pc", out_pc, 32'hC);
    check_vec("second_rd", out_rd, 3);
    check_vec("second_funct", out_funct, 32'h20);
    check_vec("second_shamt", out_shamt, 0);
    check_vec("second_occ", occupancy, 1);
    step();
    check_vec("empty_valid", out_valid, 0);
    check_vec("empty_occ", occupancy, 0);
    check_vec("empty_instr", out_instr, 0);

    // Streaming: one word per cycle with no bubbles.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_pc = 32'(4 * (i + 1)); in_instr = 32'h100 + 32'(i);
      step();
      check_vec($sformatf("stream_pc%0d", i), out_pc, 32'(4 * (i + 1)));
      check_vec($sformatf("stream_occ%0d", i), occupancy, 1);
    end
    in_valid = 1'b0;
    step();
    check_vec("stream_end_valid", out_valid, 0);

    // Flush while full with a valid jump on the input.
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h40; in_instr = 32'h1111_0000;
    step();
    in_pc = 32'h44; in_instr = 32'h2222_0000;
    step();
    check_vec("pre_flush_occ", occupancy, 2);
    flush = 1'b1; in_pc = 32'h48; in_instr = 32'h0800_0010;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_vec("flush_occ", occupancy, 0);
    check_vec("flush_valid", out_valid, 0);
    check_vec("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec($sformatf("flush_quiet%0d", i), out_instr, 0);
    end

    // Reset while full, then a NOP push must appear normally.
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h50; in_instr = 32'hAAAA_0001;
    step();
    in_pc = 32'h54; in_instr = 32'hBBBB_0002;
    step();
    check_vec("pre_rst_occ", occupancy, 2);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_vec("mid_rst_occ", occupancy, 0);
    check_vec("mid_rst_valid", out_valid, 0);
    check_vec("mid_rst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_pc = 32'h60; in_instr = 32'h0000_0000;
    step();
    in_valid = 1'b0;
    check_vec("nop_valid", out_valid, 1);
    check_vec("nop_pc", out_pc, 32'h60);
    check_vec("nop_instr", out_instr, 0);
    check_vec("nop_occ", occupancy, 1);
    out_ready = 1'b1;
    step();
    check_vec("nop_drained", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
